// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//
// Register file with two registered read ports, one registered debug tap,
// two write ports and a per-register "pending" (busy) scoreboard bit.
//
// Write port 1 (memory result) overrides write port 0 (execute result) when
// both target the same register in one cycle. A lock marks a register as
// pending and takes priority over a same-cycle write, because the lock
// belongs to a newer producer. Any write clears the pending bit.
//
// With ZERO_REG=1, register 0 reads as zero and is never busy. Writes and
// locks aimed at register 0 are discarded.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - reads return same-edge write data (port 1 over port 0) and
//               the post-update busy value
//   undefined - reads return the pre-write entry and the pre-update busy bit
//
// Parameters:
//   DATA_W   register / bus width in bits
//   ADDR_W   register index width; DEPTH = 2**ADDR_W
//   ZERO_REG 1 = register 0 is hardwired to zero
//
// Ports:
//   clk                         single clock, rising edge
//   rst_n                       asynchronous active-low reset
//   ra, rb                      read indices, ports A and B
//   bus_a, bus_b                registered read data (one-cycle latency)
//   busy_a, busy_b              registered pending flag of the register read
//   w0_en, w0_addr, w0_data     write port 0 (execute result)
//   w1_en, w1_addr, w1_data     write port 1 (memory result)
//   lock_en, lock_addr          mark a destination register as pending
//   dbg_addr, dbg_data          registered debug tap
// ---------------------------------------------------------------------------
module regfile_multiport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage and scoreboard
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Registered outputs
    logic [DATA_W-1:0] bus_a_q,    bus_a_d;
    logic [DATA_W-1:0] bus_b_q,    bus_b_d;
    logic              busy_a_q,   busy_a_d;
    logic              busy_b_q,   busy_b_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

    // Qualified write/lock strobes (register 0 is protected when ZERO_REG=1)
    logic w0_ok;
    logic w1_ok;
    logic lock_ok;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    assign w0_ok   = w0_en   && !is_zero_reg(w0_addr);
    assign w1_ok   = w1_en   && !is_zero_reg(w1_addr);
    assign lock_ok = lock_en && !is_zero_reg(lock_addr);

    // ------------------------------------------------------------------
    // Next-state of storage and scoreboard.
    // Ordering encodes priority: w1 after w0 (port 1 wins), lock after the
    // writes (lock wins over a same-cycle write clear).
    // ------------------------------------------------------------------
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;

        if (w0_ok) begin
            mem_d[w0_addr]  = w0_data;
            busy_d[w0_addr] = 1'b0;
        end
        if (w1_ok) begin
            mem_d[w1_addr]  = w1_data;
            busy_d[w1_addr] = 1'b0;
        end
        if (lock_ok) begin
            busy_d[lock_addr] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read ports and debug tap
    // ------------------------------------------------------------------
    always_comb begin
        bus_a_d    = '0;
        bus_b_d    = '0;
        busy_a_d   = 1'b0;
        busy_b_d   = 1'b0;
        dbg_data_d = '0;

`ifdef REGFILE_BYPASS_EN
        // Sourcing from the next-state arrays forwards same-edge write data
        // (already resolved w1 over w0) and the post-update busy bits.
        if (!is_zero_reg(ra)) begin
            bus_a_d  = mem_d[ra];
            busy_a_d = busy_d[ra];
        end
        if (!is_zero_reg(rb)) begin
            bus_b_d  = mem_d[rb];
            busy_b_d = busy_d[rb];
        end
        if (!is_zero_reg(dbg_addr)) begin
            dbg_data_d = mem_d[dbg_addr];
        end
`else
        if (!is_zero_reg(ra)) begin
            bus_a_d  = mem_q[ra];
            busy_a_d = busy_q[ra];
        end
        if (!is_zero_reg(rb)) begin
            bus_b_d  = mem_q[rb];
            busy_b_d = busy_q[rb];
        end
        if (!is_zero_reg(dbg_addr)) begin
            dbg_data_d = mem_q[dbg_addr];
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            bus_a_q    <= '0;
            bus_b_q    <= '0;
            busy_a_q   <= 1'b0;
            busy_b_q   <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q     <= busy_d;
            bus_a_q    <= bus_a_d;
            bus_b_q    <= bus_b_d;
            busy_a_q   <= busy_a_d;
            busy_b_q   <= busy_b_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign bus_a    = bus_a_q;
    assign bus_b    = bus_b_q;
    assign busy_a   = busy_a_q;
    assign busy_b   = busy_b_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
//
// Directed bench for regfile_multiport (default parameters: 16-bit data,
// 8 registers, register 0 hardwired to zero). A reference model of the
// register file and scoreboard predicts every registered output; a compare
// process checks all five outputs each cycle. Literal expectations pin the
// main scenarios independently of the model. Honours REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int ND = 8;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ra, rb, dbg_addr;
    logic [DW-1:0] bus_a, bus_b, dbg_data;
    logic          busy_a, busy_b;
    logic          w0_en, w1_en, lock_en;
    logic [AW-1:0] w0_addr, w1_addr, lock_addr;
    logic [DW-1:0] w0_data, w1_data;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rb       (rb),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .w0_en    (w0_en),
        .w0_addr  (w0_addr),
        .w0_data  (w0_data),
        .w1_en    (w1_en),
        .w1_addr  (w1_addr),
        .w1_data  (w1_data),
        .lock_en  (lock_en),
        .lock_addr(lock_addr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%04h expected 0x%04h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: contents and pending flags as plain arrays.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_reg  [ND];
    logic          m_pend [ND];
    logic [DW-1:0] n_reg  [ND];
    logic          n_pend [ND];
    logic [DW-1:0] e_bus_a, e_bus_b, e_dbg;
    logic          e_busy_a, e_busy_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
            e_bus_a = '0; e_bus_b = '0; e_dbg = '0;
            e_busy_a = 1'b0; e_busy_b = 1'b0;
        end else begin
            n_reg  = m_reg;
            n_pend = m_pend;
            if (w0_en) begin n_reg[w0_addr] = w0_data; n_pend[w0_addr] = 1'b0; end
            if (w1_en) begin n_reg[w1_addr] = w1_data; n_pend[w1_addr] = 1'b0; end
            if (lock_en) n_pend[lock_addr] = 1'b1;
            n_reg[0]  = '0;      // register 0 is constant zero, never pending
            n_pend[0] = 1'b0;
            if (BYP) begin
                e_bus_a = n_reg[ra];  e_busy_a = n_pend[ra];
                e_bus_b = n_reg[rb];  e_busy_b = n_pend[rb];
                e_dbg   = n_reg[dbg_addr];
            end else begin
                e_bus_a = m_reg[ra];  e_busy_a = m_pend[ra];
                e_bus_b = m_reg[rb];  e_busy_b = m_pend[rb];
                e_dbg   = m_reg[dbg_addr];
            end
            m_reg  = n_reg;
            m_pend = n_pend;
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_bus_a",  bus_a,          e_bus_a);
            chk("model_bus_b",  bus_b,          e_bus_b);
            chk("model_busy_a", {15'b0, busy_a}, {15'b0, e_busy_a});
            chk("model_busy_b", {15'b0, busy_b}, {15'b0, e_busy_b});
            chk("model_dbg",    dbg_data,       e_dbg);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_en = 1'b0; w1_en = 1'b0; lock_en = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        w0_en = 1'b1; w0_addr = a; w0_data = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        w1_en = 1'b1; w1_addr = a; w1_data = d;
    endtask

    task automatic lk(input logic [AW-1:0] a);
        lock_en = 1'b1; lock_addr = a;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_bus_a"},  bus_a,            16'h0000);
        chk({name, "_bus_b"},  bus_b,            16'h0000);
        chk({name, "_busy_a"}, {15'b0, busy_a},  16'h0000);
        chk({name, "_busy_b"}, {15'b0, busy_b},  16'h0000);
        chk({name, "_dbg"},    dbg_data,         16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        ra = '0; rb = '0; dbg_addr = '0;
        w0_addr = '0; w1_addr = '0; lock_addr = '0;
        w0_data = '0; w1_data = '0;
        idle();
        #2;
        chk_all_zero("reset");
        #20;
        tick();
        rst_n = 1'b1;

        // Basic write then read, one-cycle read latency
        wr0(3'd5, 16'h0002); tick(); idle();
        ra = 3'd5; tick();
        chk("w5_bus_a",  bus_a,           16'h0002);
        chk("w5_busy_a", {15'b0, busy_a}, 16'h0000);

        // Same-address dual write: port 1 wins
        wr0(3'd3, 16'h1111); wr1(3'd3, 16'h2222); tick(); idle();
        rb = 3'd3; dbg_addr = 3'd3; tick();
        chk("dual_bus_b", bus_b,    16'h2222);
        chk("dual_dbg",   dbg_data, 16'h2222);

        // Register 0: writes and locks ignored
        wr0(3'd0, 16'hFFFF); lk(3'd0); tick(); idle();
        ra = 3'd0; tick();
        chk("zero_bus_a",  bus_a,           16'h0000);
        chk("zero_busy_a", {15'b0, busy_a}, 16'h0000);

        // Lock / write-clear / lock-beats-write on register 6
        lk(3'd6); tick(); idle();
        ra = 3'd6; tick();
        chk("lock6_busy", {15'b0, busy_a}, 16'h0001);
        wr1(3'd6, 16'h0007); tick(); idle(); tick();
        chk("wr6_busy",  {15'b0, busy_a}, 16'h0000);
        chk("wr6_bus_a", bus_a,           16'h0007);
        lk(3'd6); wr0(3'd6, 16'h0055); tick(); idle(); tick();
        chk("lockwr6_busy",  {15'b0, busy_a}, 16'h0001);
        chk("lockwr6_bus_a", bus_a,           16'h0055);

        // Same-cycle read/write of register 4
        ra = 3'd4; wr0(3'd4, 16'hABCD); tick(); idle();
        chk("rw4_same", bus_a, BYP ? 16'hABCD : 16'h0000);
        tick();
        chk("rw4_after", bus_a, 16'hABCD);

        // Same-cycle lock and read of register 2 (busy forwarding)
        ra = 3'd2; lk(3'd2); tick(); idle();
        chk("lockrd2_same", {15'b0, busy_a}, BYP ? 16'h0001 : 16'h0000);
        wr1(3'd2, 16'h0202); tick(); idle();
        chk("wrrd2_same", {15'b0, busy_a}, BYP ? 16'h0000 : 16'h0001);

        // Back-to-back traffic on every port, checked by the model
        for (int i = 0; i < 24; i++) begin
            wr0(AW'(i), DW'(i * 16'h0101));
            w1_en = (i % 3) != 0; w1_addr = AW'(i + 3); w1_data = DW'(16'hC000 + i);
            lock_en = (i % 2) == 0; lock_addr = AW'(i * 5);
            ra = AW'(i * 3); rb = AW'(i + 1); dbg_addr = AW'(i * 7);
            tick();
        end
        idle();
        for (int i = 0; i < ND; i++) begin
            ra = AW'(i); rb = AW'(ND - 1 - i); dbg_addr = AW'(i);
            tick();
        end

        // Load register 2, lock it, then pulse reset between edges
        wr0(3'd2, 16'h5A5A); lk(3'd2); tick(); idle();
        ra = 3'd2; rb = 3'd3; dbg_addr = 3'd5; tick();
        chk("pre_rst_bus_a", bus_a,           16'h5A5A);
        chk("pre_rst_busy",  {15'b0, busy_a}, 16'h0001);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #1 rst_n = 1'b1;
        for (int i = 0; i < ND; i++) begin
            ra = AW'(i); rb = AW'(i); dbg_addr = AW'(i);
            tick();
            chk("post_rst_bus_a",  bus_a,           16'h0000);
            chk("post_rst_busy_a", {15'b0, busy_a}, 16'h0000);
        end

        // Write and lock presented across an edge while reset is held
        rst_n = 1'b0; wr0(3'd1, 16'h3333); lk(3'd1); tick(); tick();
        idle(); rst_n = 1'b1;
        ra = 3'd1; tick(); tick();
        chk("rst_discard_bus_a",  bus_a,           16'h0000);
        chk("rst_discard_busy_a", {15'b0, busy_a}, 16'h0000);

        // Resume after reset: first edge with rst_n high is live
        wr1(3'd7, 16'h7777); tick(); idle();
        ra = 3'd7; tick();
        chk("resume_bus_a", bus_a, 16'h7777);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register and bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning register index width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning 1 makes register 0 hardwired to zero.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports ra, rb  input  ADDR_W  read indices for ports A and B.
REQ-007 SHALL have ports bus_a, bus_b  output  DATA_W  registered read data.
REQ-008 SHALL have ports busy_a, busy_b  output  1  registered pending flag of the register read.
REQ-009 SHALL have ports w0_en (1), w0_addr (ADDR_W), w0_data (DATA_W), all inputs: write port 0 (execute result).
REQ-010 SHALL have ports w1_en (1), w1_addr (ADDR_W), w1_data (DATA_W), all inputs: write port 1 (memory result).
REQ-011 SHALL have ports lock_en (1), lock_addr (ADDR_W), both inputs: mark a destination register as pending.
REQ-012 SHALL have port dbg_addr  input  ADDR_W  and port dbg_data  output  DATA_W  registered debug tap.

Function
REQ-013 SHALL, on every rising edge, load bus_a, bus_b, busy_a, busy_b and dbg_data from the entries at ra, rb and dbg_addr; read latency is one cycle.
REQ-014 SHALL write w0_data to entry w0_addr when w0_en is high, and w1_data to entry w1_addr when w1_en is high, in the same edge.
REQ-015 SHALL, when both ports write the same address in one cycle, store w1_data (port 1 wins).
REQ-016 SHALL, when ZERO_REG=1, ignore writes and locks to index 0, and return zero with busy 0 for every read of index 0.
REQ-017 SHALL set the busy bit of lock_addr when lock_en is high.
REQ-018 SHALL clear the busy bit of any address written by w0 or w1.
REQ-019 SHALL, when a lock and a write target the same address in one cycle, leave busy set (lock wins: newer producer).
REQ-020 SHALL keep all unaddressed entries and busy bits unchanged.
REQ-021 SHALL have no internal limit on back-to-back writes or locks; every cycle is independent.

Reset
REQ-022 SHALL, while rst_n is low and independent of clk, clear all DEPTH entries, all busy bits, bus_a, bus_b, busy_a, busy_b and dbg_data to zero.
REQ-023 SHALL discard any write or lock presented in the cycle where rst_n deasserts mid-operation, if rst_n is low at that edge.
REQ-024 SHALL resume normal operation on the first rising edge with rst_n high.

Configuration
REQ-025 SHALL implement write-to-read forwarding only when macro REGFILE_BYPASS_EN is defined.
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, load bus_a/bus_b/dbg_data with the data written this edge when the read index matches a write (w1 over w0), and load busy_a/busy_b with the post-update busy value.
REQ-027 SHALL, without REGFILE_BYPASS_EN, return the pre-write entry value and pre-update busy value for a same-cycle read/write match.

Verification
REQ-028 SHALL cover: reset, then write w0 addr 5 = 0x0002; next cycle ra=5 -> bus_a = 0x0002 one cycle later, busy_a = 0.
REQ-029 SHALL cover: w0 addr 3 = 0x1111 and w1 addr 3 = 0x2222 same cycle -> later read of 3 returns 0x2222.
REQ-030 SHALL cover: write addr 0 = 0xFFFF with ZERO_REG=1 -> read of 0 returns 0x0000, busy 0; lock_addr 0 has no effect.
REQ-031 SHALL cover: lock 6, read 6 -> busy_a = 1; then w1 addr 6 = 0x0007 -> busy 0; lock and write 6 same cycle -> busy stays 1.
REQ-032 SHALL cover: ra=4 while w0 writes 4 = 0xABCD, old value 0x0000 -> bus_a = 0xABCD with REGFILE_BYPASS_EN, 0x0000 without.
REQ-033 SHALL cover: entries loaded and reg 2 locked, rst_n pulsed low between edges -> all outputs and busy bits zero immediately, all reads return 0x0000 after release.
